// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
// Time fields are fixed at 6 bits internally (0..59); ports widen them to CNT_W.
// The helper functions cover the LAP_DELTA_EN review path.
package lap_stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SPLIT,
        STOPPED,
        REVIEW
    } sw_state_t;

    localparam int unsigned SEC_MAX       = 59;
    localparam int unsigned MIN_MAX       = 59;
    localparam int unsigned SECS_PER_HOUR = 3600;
    localparam int unsigned FIELD_W       = 6;

    typedef struct packed {
        logic [FIELD_W-1:0] minutes;
        logic [FIELD_W-1:0] seconds;
    } sw_time_t;

    // One-second advance, wrapping 59:59 to 00:00.
    function automatic sw_time_t time_inc(sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.seconds == FIELD_W'(SEC_MAX)) begin
            r.seconds = '0;
            r.minutes = (t.minutes == FIELD_W'(MIN_MAX)) ? '0 : t.minutes + FIELD_W'(1);
        end else begin
            r.seconds = t.seconds + FIELD_W'(1);
        end
        return r;
    endfunction

    function automatic logic [11:0] time_to_secs(sw_time_t t);
        return 12'(t.minutes) * 12'd60 + 12'(t.seconds);
    endfunction

    function automatic sw_time_t secs_to_time(logic [11:0] s);
        sw_time_t r;
        r.minutes = FIELD_W'(s / 12'd60);
        r.seconds = FIELD_W'(s % 12'd60);
        return r;
    endfunction

    // (a - b) modulo one hour; the add-back is ordered so 12 bits never overflow.
    function automatic sw_time_t lap_delta(sw_time_t a, sw_time_t b);
        logic [11:0] sa;
        logic [11:0] sb;
        logic [11:0] d;
        sa = time_to_secs(a);
        sb = time_to_secs(b);
        if (sa >= sb) d = sa - sb;
        else          d = (12'(SECS_PER_HOUR) - sb) + sa;
        return secs_to_time(d);
    endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button and display bundle between the clock top level and the lap stopwatch.
// master: button source / display consumer; slave: the stopwatch.
interface lap_stopwatch_if #(
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned LAP_DEPTH = 4
);
    localparam int unsigned LC_W = $clog2(LAP_DEPTH + 1);

    logic             start_stop_btn;
    logic             mode_btn;
    logic             rd_btn;
    logic [CNT_W-1:0] minutes_out;
    logic [CNT_W-1:0] seconds_out;
    logic             running;
    logic             split_active;
    logic [LC_W-1:0]  lap_count;
    logic             lap_full;
    logic             lap_overflow;

    modport master (
        output start_stop_btn, mode_btn, rd_btn,
        input  minutes_out, seconds_out, running, split_active,
        input  lap_count, lap_full, lap_overflow
    );

    modport slave (
        input  start_stop_btn, mode_btn, rd_btn,
        output minutes_out, seconds_out, running, split_active,
        output lap_count, lap_full, lap_overflow
    );
endinterface

// File: rtl/lap_stopwatch_lap_buffer.sv
// Append-only lap register file: index 0 is the oldest capture.
// A push into a full buffer is dropped and sets the sticky overflow flag.
// LAP_DELTA_EN adds a second read port for the previous entry.
module lap_buffer #(
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned DATA_W    = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  logic                                  clear,
    input  logic [DATA_W-1:0]                     push_data,
    input  logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] rd_idx,
    output logic [DATA_W-1:0]                     rd_data,
`ifdef LAP_DELTA_EN
    input  logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] prev_idx,
    output logic [DATA_W-1:0]                     prev_data,
`endif
    output logic [$clog2(LAP_DEPTH + 1)-1:0]      count,
    output logic                                  full,
    output logic                                  overflow
);
    localparam int unsigned LC_W  = $clog2(LAP_DEPTH + 1);
    localparam int unsigned IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [DATA_W-1:0] mem [LAP_DEPTH];
    logic [LC_W-1:0]   count_q;
    logic              full_q;
    logic              ovf_q;

    // Storage, fill count and flags; clear empties the buffer without touching old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (push) begin
            if (full_q) begin
                ovf_q <= 1'b1;
            end else begin
                mem[count_q[IDX_W-1:0]] <= push_data;
                count_q <= count_q + LC_W'(1);
                full_q  <= (count_q == LC_W'(LAP_DEPTH - 1));
            end
        end
    end

    assign rd_data  = mem[rd_idx];
`ifdef LAP_DELTA_EN
    assign prev_data = mem[prev_idx];
`endif
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: MM:SS counter with split freeze and a review-able lap buffer.
// Optional macro LAP_DELTA_EN: REVIEW shows lap-to-lap differences instead of absolute times.
// All display/status outputs are registered from next-state values (one-cycle latency).
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned CNT_W     = 6
) (
    input  logic           clk,
    input  logic           rst,
    lap_stopwatch_if.slave sw
);
    localparam int unsigned LC_W   = $clog2(LAP_DEPTH + 1);
    localparam int unsigned IDX_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DATA_W = 2 * CNT_W;

    sw_state_t         state, state_nxt;
    logic              ss_q, md_q, rd_q;
    logic              ev_ss, ev_md, ev_rd;
    logic              running_now, tick;
    logic [PRE_W-1:0]  presc, presc_nxt;
    sw_time_t          cnt, cnt_nxt;
    sw_time_t          frozen, frozen_nxt;
    sw_time_t          lap_abs, lap_view, disp;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              push, clear;
    logic [DATA_W-1:0] push_data, rd_data;
    logic [LC_W-1:0]   lap_cnt;
    logic              lap_full, lap_ovf;
`ifdef LAP_DELTA_EN
    logic [IDX_W-1:0]  prev_idx;
    logic [DATA_W-1:0] prev_data;
    sw_time_t          lap_prev;
`endif

    // Button history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ss_q <= 1'b0;
            md_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            ss_q <= sw.start_stop_btn;
            md_q <= sw.mode_btn;
            rd_q <= sw.rd_btn;
        end
    end

    // Rising edges with start_stop > mode > rd priority; losers are dropped.
    always_comb begin
        ev_ss = sw.start_stop_btn & ~ss_q;
        ev_md = sw.mode_btn & ~md_q & ~ev_ss;
        ev_rd = sw.rd_btn & ~rd_q & ~ev_ss & ~ev_md;
    end

    // Prescaler terminal count gives the one-second tick while running.
    always_comb begin
        running_now = (state == RUN) || (state == SPLIT);
        tick        = running_now && (presc == PRE_W'(TICK_DIV - 1));
    end

    // Working registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            presc  <= '0;
            cnt    <= '0;
            frozen <= '0;
            idx    <= '0;
        end else begin
            state  <= state_nxt;
            presc  <= presc_nxt;
            cnt    <= cnt_nxt;
            frozen <= frozen_nxt;
            idx    <= idx_nxt;
        end
    end

    // Next-state, counter advance, lap capture and review index.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = tick ? time_inc(cnt) : cnt;
        frozen_nxt = frozen;
        idx_nxt    = idx;
        push       = 1'b0;
        clear      = 1'b0;
        presc_nxt  = presc;
        if (running_now) presc_nxt = tick ? '0 : presc + PRE_W'(1);
        case (state)
            IDLE: begin
                if (ev_ss) state_nxt = RUN;
            end
            RUN: begin
                if (ev_ss) begin
                    state_nxt = STOPPED;
                end else if (ev_md) begin
                    push       = 1'b1;
                    frozen_nxt = cnt;
                    state_nxt  = SPLIT;
                end
            end
            SPLIT: begin
                if (ev_ss)      state_nxt = STOPPED;
                else if (ev_md) state_nxt = RUN;
            end
            STOPPED: begin
                if (ev_ss) begin
                    state_nxt = RUN;
                end else if (ev_md) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    presc_nxt = '0;
                    clear     = 1'b1;
                end else if (ev_rd && (lap_cnt != '0)) begin
                    state_nxt = REVIEW;
                    idx_nxt   = '0;
                end
            end
            REVIEW: begin
                if (ev_ss) begin
                    state_nxt = RUN;
                end else if (ev_md) begin
                    state_nxt = STOPPED;
                end else if (ev_rd) begin
                    idx_nxt = (LC_W'(idx) + LC_W'(1) >= lap_cnt) ? '0 : idx + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push_data = {CNT_W'(cnt.minutes), CNT_W'(cnt.seconds)};
`ifdef LAP_DELTA_EN
    assign prev_idx = idx_nxt - IDX_W'(1);
`endif

    lap_buffer #(
        .LAP_DEPTH (LAP_DEPTH),
        .DATA_W    (DATA_W)
    ) u_lap_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .clear     (clear),
        .push_data (push_data),
        .rd_idx    (idx_nxt),
        .rd_data   (rd_data),
`ifdef LAP_DELTA_EN
        .prev_idx  (prev_idx),
        .prev_data (prev_data),
`endif
        .count     (lap_cnt),
        .full      (lap_full),
        .overflow  (lap_ovf)
    );

    // Lap shown in REVIEW: absolute, or difference from the previous lap for idx>0.
    always_comb begin
        lap_abs.minutes = rd_data[CNT_W +: FIELD_W];
        lap_abs.seconds = rd_data[0 +: FIELD_W];
`ifdef LAP_DELTA_EN
        lap_prev.minutes = prev_data[CNT_W +: FIELD_W];
        lap_prev.seconds = prev_data[0 +: FIELD_W];
        lap_view = (idx_nxt != '0) ? lap_delta(lap_abs, lap_prev) : lap_abs;
`else
        lap_view = lap_abs;
`endif
    end

    // Display source selected by the state being entered.
    always_comb begin
        disp = '0;
        case (state_nxt)
            RUN, STOPPED: disp = cnt_nxt;
            SPLIT:        disp = frozen_nxt;
            REVIEW:       disp = lap_view;
            default:      disp = '0;
        endcase
    end

    // Registered display and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw.minutes_out  <= '0;
            sw.seconds_out  <= '0;
            sw.running      <= 1'b0;
            sw.split_active <= 1'b0;
        end else begin
            sw.minutes_out  <= CNT_W'(disp.minutes);
            sw.seconds_out  <= CNT_W'(disp.seconds);
            sw.running      <= (state_nxt == RUN) || (state_nxt == SPLIT);
            sw.split_active <= (state_nxt == SPLIT);
        end
    end

    assign sw.lap_count    = lap_cnt;
    assign sw.lap_full     = lap_full;
    assign sw.lap_overflow = lap_ovf;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch against a seconds-based behavioural model.
// Honours LAP_DELTA_EN when defined for the review expectations.
module tb_lap_stopwatch;
    localparam int unsigned TD  = 1;
    localparam int unsigned LD  = 4;
    localparam int unsigned CW  = 6;
    localparam int unsigned LCW = $clog2(LD + 1);
    localparam int unsigned VW  = 2 * CW + LCW + 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lap_stopwatch_if #(.CNT_W(CW), .LAP_DEPTH(LD)) sw ();

    lap_stopwatch #(.TICK_DIV(TD), .LAP_DEPTH(LD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, required finish before 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: whole seconds, a queue of lap seconds, a mode tag.
    typedef enum {M_IDLE, M_RUN, M_SPLIT, M_STOP, M_REVIEW} mode_t;
    mode_t m_state;
    int    m_secs, m_presc, m_frozen, m_idx;
    int    laps[$];
    bit    m_ovf;
    bit    p_ss, p_md, p_rd;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {sw.minutes_out, sw.seconds_out, sw.running, sw.split_active,
                      sw.lap_count, sw.lap_full, sw.lap_overflow};

    function automatic void model_reset();
        m_state = M_IDLE; m_secs = 0; m_presc = 0; m_frozen = 0; m_idx = 0;
        laps.delete(); m_ovf = 0; p_ss = 0; p_md = 0; p_rd = 0;
    endfunction

    function automatic void model_step(bit ss, bit md, bit rd);
        bit e_ss, e_md, e_rd, tk;
        int old;
        e_ss = ss && !p_ss;
        e_md = md && !p_md && !e_ss;
        e_rd = rd && !p_rd && !e_ss && !e_md;
        p_ss = ss; p_md = md; p_rd = rd;
        tk = 0;
        if (m_state == M_RUN || m_state == M_SPLIT) begin
            if (m_presc == TD - 1) begin tk = 1; m_presc = 0; end
            else m_presc++;
        end
        old = m_secs;
        if (tk) m_secs = (m_secs + 1) % 3600;
        case (m_state)
            M_IDLE:  if (e_ss) m_state = M_RUN;
            M_RUN: begin
                if (e_ss) m_state = M_STOP;
                else if (e_md) begin
                    if (laps.size() < LD) laps.push_back(old); else m_ovf = 1;
                    m_frozen = old;
                    m_state = M_SPLIT;
                end
            end
            M_SPLIT: begin
                if (e_ss) m_state = M_STOP;
                else if (e_md) m_state = M_RUN;
            end
            M_STOP: begin
                if (e_ss) m_state = M_RUN;
                else if (e_md) begin
                    m_state = M_IDLE; m_secs = 0; laps.delete(); m_ovf = 0;
                end else if (e_rd && laps.size() > 0) begin
                    m_state = M_REVIEW; m_idx = 0;
                end
            end
            M_REVIEW: begin
                if (e_ss) m_state = M_RUN;
                else if (e_md) m_state = M_STOP;
                else if (e_rd) m_idx = (m_idx + 1) % laps.size();
            end
            default: m_state = M_IDLE;
        endcase
        if (m_state == M_IDLE) m_presc = 0;
    endfunction

    function automatic int exp_disp();
        case (m_state)
            M_RUN, M_STOP: return m_secs;
            M_SPLIT:       return m_frozen;
            M_REVIEW: begin
`ifdef LAP_DELTA_EN
                if (m_idx > 0) return (laps[m_idx] - laps[m_idx-1] + 3600) % 3600;
`endif
                return laps[m_idx];
            end
            default:       return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int v;
        v = exp_disp();
        return {CW'(v / 60), CW'(v % 60), (m_state == M_RUN || m_state == M_SPLIT),
                (m_state == M_SPLIT), LCW'(laps.size()), (laps.size() == LD), m_ovf};
    endfunction

    // One clock: drive buttons at the falling edge, advance model, sample at next falling edge.
    task automatic cycle(bit ss, bit md, bit rd);
        sw.start_stop_btn = ss;
        sw.mode_btn       = md;
        sw.rd_btn         = rd;
        model_step(ss, md, rd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sw.start_stop_btn = 1'b0; sw.mode_btn = 1'b0; sw.rd_btn = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic wait_count(int v);
        for (int k = 0; k < 4000 && m_secs != v; k++) cycle(0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_zero: got %h expected 0", dut_vec);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_count_stop();
        do_reset();
        cycle(1, 0, 0);
        repeat (74) cycle(0, 0, 0);
        cycle(1, 0, 0);
        checks++;
        if ({sw.minutes_out, sw.seconds_out, sw.running} !== {CW'(1), CW'(15), 1'b0}) begin
            errors++; $display("FAIL stop_75: got %0d:%0d run=%b expected 1:15 run=0",
                               sw.minutes_out, sw.seconds_out, sw.running);
        end
        repeat (20) cycle(0, 0, 0);
        checks++;
        if ({sw.minutes_out, sw.seconds_out, sw.running} !== {CW'(1), CW'(15), 1'b0}) begin
            errors++; $display("FAIL stop_hold: got %0d:%0d run=%b expected 1:15 run=0",
                               sw.minutes_out, sw.seconds_out, sw.running);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL stop_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1, 0, 0);
        repeat (3601) cycle(0, 0, 0);
        checks++;
        if ({sw.minutes_out, sw.seconds_out, sw.running} !== {CW'(0), CW'(1), 1'b1}) begin
            errors++; $display("FAIL wrap_3601: got %0d:%0d run=%b expected 0:1 run=1",
                               sw.minutes_out, sw.seconds_out, sw.running);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL wrap_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_split();
        do_reset();
        cycle(1, 0, 0);
        repeat (50) cycle(0, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 28; i++) begin
            checks++;
            if ({sw.minutes_out, sw.seconds_out, sw.split_active} !== {CW'(0), CW'(50), 1'b1}) begin
                errors++; $display("FAIL split_freeze[%0d]: got %0d:%0d split=%b expected 0:50 split=1",
                                   i, sw.minutes_out, sw.seconds_out, sw.split_active);
            end
            cycle(0, 0, 0);
        end
        cycle(0, 1, 0);
        checks++;
        if ({sw.minutes_out, sw.seconds_out, sw.split_active} !== {CW'(1), CW'(20), 1'b0}) begin
            errors++; $display("FAIL split_release: got %0d:%0d split=%b expected 1:20 split=0",
                               sw.minutes_out, sw.seconds_out, sw.split_active);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL split_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lap_overflow();
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(2, 8)) cycle(0, 0, 0);
            cycle(0, 1, 0);
            cycle(0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL ovf_split[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
            repeat ($urandom_range(1, 5)) cycle(0, 0, 0);
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        checks++;
        if ({sw.lap_count, sw.lap_full, sw.lap_overflow} !== {LCW'(LD), 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_flags: got cnt=%0d full=%b ovf=%b expected cnt=%0d full=1 ovf=1",
                               sw.lap_count, sw.lap_full, sw.lap_overflow, LD);
        end
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL ovf_review[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
            cycle(0, 0, 0);
        end
    endtask

    task automatic test_review();
        int exp_s[4];
        int got;
`ifdef LAP_DELTA_EN
        exp_s = '{10, 15, 15, 10};
`else
        exp_s = '{10, 25, 40, 10};
`endif
        do_reset();
        cycle(1, 0, 0);
        foreach (exp_s[j]) begin
            if (j < 3) begin
                wait_count(10 + 15 * j);
                cycle(0, 1, 0);
                cycle(0, 0, 0);
                cycle(0, 1, 0);
                cycle(0, 0, 0);
            end
        end
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            got = int'(sw.minutes_out) * 60 + int'(sw.seconds_out);
            checks++;
            if (got !== exp_s[i]) begin
                errors++; $display("FAIL review[%0d]: got %0d s expected %0d s", i, got, exp_s[i]);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL review_model[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
            cycle(0, 0, 0);
        end
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL review_clear: got %h expected 0", dut_vec);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        checks++;
        if ({sw.running, sw.lap_count, sw.seconds_out} !== {1'b0, LCW'(0), CW'(2)}) begin
            errors++; $display("FAIL rd_no_laps: got run=%b cnt=%0d sec=%0d expected run=0 cnt=0 sec=2",
                               sw.running, sw.lap_count, sw.seconds_out);
        end
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        cycle(1, 1, 0);
        checks++;
        if ({sw.running, sw.split_active, sw.lap_count} !== {1'b0, 1'b0, LCW'(1)}) begin
            errors++; $display("FAIL ss_md_same: got run=%b split=%b cnt=%0d expected run=0 split=0 cnt=1",
                               sw.running, sw.split_active, sw.lap_count);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL ss_md_model: got %h expected %h", dut_vec, exp_vec());
        end
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        repeat (7) cycle(0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL ss_rd_model: got %h expected %h", dut_vec, exp_vec());
        end
        rst = 1'b0;
        sw.start_stop_btn = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_mid_run: got %h expected 0", dut_vec);
        end
        cycle(0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL post_reset: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                sw.start_stop_btn = 1'($urandom_range(0, 1));
                sw.mode_btn       = 1'($urandom_range(0, 1));
                sw.rd_btn         = 1'($urandom_range(0, 1));
                @(negedge clk);
                model_reset();
                rst = 1'b1;
            end else begin
                cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        sw.start_stop_btn = 1'b0;
        sw.mode_btn       = 1'b0;
        sw.rd_btn         = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_count_stop();
        test_wrap();
        test_split();
        test_lap_overflow();
        test_review();
        test_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised stopwatch with a lap-capture buffer. It succeeds the single-split stopwatch used inside the digital-clock top level.
- Counts MM:SS from a prescaled tick.
- Supports split (display freeze while the count continues).
- Stores up to LAP_DEPTH lap times, which can be reviewed after stopping.
- Driven by the clock top's mode and increment button pulses; its display outputs feed the top-level display mux.

Parameters:
TICK_DIV, 1, clk cycles per stopwatch second (>=1)
LAP_DEPTH, 4, lap buffer entries (>=1)
CNT_W, 6, width of each minutes/seconds field (>=6)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
start_stop_btn  in  1  increment button; rising edge = start/stop event
mode_btn  in  1  mode button; rising edge = split/release/clear/exit event
rd_btn  in  1  rising edge = review-next event
minutes_out  out  CNT_W  displayed minutes
seconds_out  out  CNT_W  displayed seconds
running  out  1  counter advancing
split_active  out  1  display frozen (SPLIT state)
lap_count  out  $clog2(LAP_DEPTH+1)  stored laps
lap_full  out  1  lap_count==LAP_DEPTH
lap_overflow  out  1  sticky; a capture was dropped

Behaviour:
- Reset: rst sampled low on a clk edge sets state IDLE, counter/prescaler/laps to 0, all outputs 0, edge-detect registers 0. Reset overrides every event, including mid-run or mid-review.
- Button inputs are edge-detected internally; a level held N cycles is one event.
- Same-cycle events use priority start_stop > mode > rd; lower-priority events that cycle are discarded.
- Prescaler counts 0..TICK_DIV-1 while running; tick on terminal count.
  - Prescaler is held in STOPPED and REVIEW.
  - Prescaler is cleared on entering IDLE.
- Counter on tick: seconds 0..59; 59 wraps to 0 and increments minutes. 59:59 wraps to 00:00.
- All outputs are registered and reflect an event on the next clk edge (1-cycle latency).
- States and transitions:
  - IDLE: display 00:00.
    - start_stop -> RUN.
    - mode, rd -> no effect.
  - RUN: display live counter.
    - start_stop -> STOPPED.
    - mode -> SPLIT; captures the pre-increment counter value of that cycle into the lap buffer and freezes the display to it.
  - SPLIT: counter continues; display frozen; split_active=1.
    - mode -> RUN (display live).
    - start_stop -> STOPPED (display live, counter halted).
  - STOPPED: display live (halted) value.
    - start_stop -> RUN (resume, no clear).
    - mode -> IDLE; clears counter, laps and lap_overflow.
    - rd -> REVIEW at index 0 only if lap_count>0; otherwise ignored.
  - REVIEW: display lap[idx].
    - rd -> idx+1, wrapping to 0 after lap_count-1.
    - mode -> STOPPED.
    - start_stop -> RUN (resume).
- running=1 in RUN and SPLIT only.
- Lap buffer: write pointer append, capture in order, index 0 = oldest.
  - When full, a capture is dropped and lap_overflow is set.
  - Buffer contents are never overwritten.

Optional Feature:
LAP_DELTA_EN:
- Defined: REVIEW displays lap[idx]-lap[idx-1] for idx>0, computed modulo 3600 s and rendered as MM:SS. idx 0 shows its absolute value. Adds a subtractor and converter.
- Undefined: REVIEW displays absolute lap times; no subtractor.

Decomposition:
- Package lap_stopwatch_pkg holds:
  - state enum {IDLE, RUN, SPLIT, STOPPED, REVIEW}
  - constants SEC_MAX=59, MIN_MAX=59, SECS_PER_HOUR=3600
  - time record type {minutes, seconds}
- Sub-module lap_buffer: LAP_DEPTH x 2*CNT_W register file.
  - Inputs push, clear, rd_idx.
  - Outputs rd_data, count, full, overflow.

Test Plan:
1. Reset, start, wait 75 ticks, stop -> minutes_out=1, seconds_out=15, running=0; extra 20 cycles -> unchanged.
2. Start, 3601 ticks -> display 00:01 (wrap past 59:59); running=1.
3. Start, 50 ticks, mode -> display holds 00:50, split_active=1 for 30 ticks. Mode again -> display 01:20 next cycle.
4. Five splits (each split then release) with LAP_DEPTH=4 -> lap_count=4, lap_full=1, lap_overflow=1; the 5th value is not stored.
5. Laps captured at 00:10, 00:25, 00:40, then stop, rd x4 -> displays 00:10, 00:25, 00:40, 00:10. With LAP_DELTA_EN: 00:10, 00:15, 00:15, 00:10. Then mode, mode -> IDLE, all zero.
6. RUN with start_stop and mode in the same cycle -> STOPPED, lap_count unchanged. rst low mid-RUN -> every output 0 after the next edge.
